muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers and busy sequencing, in the EX stage beside the ALU.
//  Accepts one mult/multu/div/divu/madd/mthi/mtlo per start pulse and models fixed latency with a down-counter.
//  Produces the ID-stage stall request for HI/LO-class instructions while an operation is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu/madd (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   clock, all state on rising edge
//  reset     in   1   synchronous, active-low reset (reset==0 at a clk edge resets)
//  start     in   1   EX holds a valid md-class instr this cycle (one-cycle pulse per instr)
//  op        in   3   0 mult,1 multu,2 div,3 divu,4 madd,5 mthi,6 mtlo,7 none (ignored)
//  rs_val    in   32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
//  rt_val    in   32  forwarded rt operand (divisor / multiplier)
//  id_md     in   1   ID instr is mult/multu/div/divu/madd/mfhi/mflo/mthi/mtlo
//  busy      out  1   long operation in flight
//  stall_md  out  1   freeze PC/IF-ID, bubble ID-EX
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, hi=lo=0, pending result=0; busy=0, stall_md=0. Reset mid-op aborts; pending result discarded.
//  States IDLE, BUSY. Long op = op in {0..4}.
//  IDLE & start & long op: latch result into pend_hi/pend_lo; cnt<=MULT_CYCLES (0,1,4) or DIV_CYCLES (2,3); ->BUSY.
//  IDLE & start & op 5: hi<=rs_val next edge; op 6: lo<=rs_val; stay IDLE, busy never rises.
//  BUSY: cnt decrements each edge; at the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, ->IDLE.
//   -> busy high exactly N cycles, starting the cycle after the start edge; hi/lo stay at old values until the final edge.
//  busy = (state==BUSY), registered.
//  stall_md = id_md & (busy | (start & long op)), combinational; no stall for mthi/mtlo start (write lands before next EX read).
//  start while BUSY is a protocol violation: ignored, state/cnt/pending unchanged.
//  Arithmetic:
//   mult/madd signed 64b product; multu unsigned 64b product; hi=[63:32], lo=[31:0].
//   madd: {hi,lo} + signed(rs)*signed(rt), mod 2^64; uses hi/lo sampled at the start edge.
//   div: signed, quotient->lo, remainder->hi (sign of dividend); divu unsigned.
//   div/divu by zero: lo=32'hFFFF_FFFF, hi=rs_val.
//   div 32'h8000_0000 / -1: lo=32'h8000_0000, hi=0.
//  op 7 with start: no effect.
//  Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
// TESTING
//  1 reset=0 two edges, then reset=1 -> hi=lo=0, busy=0, stall_md=0.
//  2 mult rs=-3, rt=7 -> busy=1 for 5 cycles; hi=FFFF_FFFF, lo=FFFF_FFEB at the 5th edge; busy=0 the same cycle.
//  3 divu rs=100, rt=7 with id_md=1 held -> stall_md=1 in the start cycle plus 10 busy cycles, then 0; lo=14, hi=2.
//  4 div rs=5, rt=0 -> lo=FFFF_FFFF, hi=5; div rs=8000_0000, rt=FFFF_FFFF -> lo=8000_0000, hi=0.
//  5 mthi rs=0x1234 while IDLE -> hi=0x1234 after 1 edge, busy stays 0; mult start during BUSY -> ignored, first result intact.
//  6 reset=0 in 3rd busy cycle of a div -> busy=0, hi=lo=0 next edge; then mtlo 10, madd rs=2, rt=3 -> lo=16, hi=0 after 5 cycles.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage request and HI/LO result bundle for the multiply/divide unit
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, id_md,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, id_md,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers and ID stall request
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;

  logic        long_op, div_op;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, madd_sum;
  logic        div_zero, div_ovf;
  logic [31:0] dvsr_s, dvsr_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;

  assign long_op = (md.op <= OP_MADD);
  assign div_op  = (md.op == OP_DIV) || (md.op == OP_DIVU);

  assign prod_s   = $signed({{32{md.rs_val[31]}}, md.rs_val}) * $signed({{32{md.rt_val[31]}}, md.rt_val});
  assign prod_u   = {32'd0, md.rs_val} * {32'd0, md.rt_val};
  assign madd_sum = {hi_q, lo_q} + prod_s;

  // Divisors are forced to 1 in the special cases so the dividers never see /0 or overflow.
  assign div_zero = (md.rt_val == 32'd0);
  assign div_ovf  = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
  assign dvsr_s   = (div_zero || div_ovf) ? 32'd1 : md.rt_val;
  assign dvsr_u   = div_zero ? 32'd1 : md.rt_val;
  assign quot_s   = $signed(md.rs_val) / $signed(dvsr_s);
  assign rem_s    = $signed(md.rs_val) % $signed(dvsr_s);
  assign quot_u   = md.rs_val / dvsr_u;
  assign rem_u    = md.rs_val % dvsr_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md.op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_MADD:  {res_hi, res_lo} = madd_sum;
      OP_DIV: begin
        if (div_zero) begin
          res_hi = md.rs_val;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = md.rs_val;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    case (state)
      IDLE: begin
        if (md.start) begin
          if (long_op) begin
            pend_hi_n = res_hi;
            pend_lo_n = res_lo;
            cnt_n     = div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_n   = BUSY;
          end else if (md.op == OP_MTHI) begin
            hi_n = md.rs_val;
          end else if (md.op == OP_MTLO) begin
            lo_n = md.rs_val;
          end
        end
      end
      BUSY: begin
        // A start arriving here is a protocol violation and is deliberately dropped.
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  assign md.busy     = (state == BUSY);
  assign md.stall_md = md.id_md && (md.busy || (md.start && long_op));
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule
